// File: rtl/led_seq_pkg.sv
// Shared encodings and pattern helpers for the LED pattern sequencer.
package led_seq_pkg;

  // Widest LED bank the pattern helpers can produce; callers size-cast down.
  localparam int unsigned MAX_W = 64;

  typedef enum logic [1:0] {
    ST_ALL_ON = 2'd0,
    ST_FLASH  = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_EXPAND = 2'd3
  } state_e;

  localparam logic [MAX_W-1:0] BIT_ONE = MAX_W'(1);

  // Alternating bits with the top bit of a width-bit bank set (even width).
  function automatic logic [MAX_W-1:0] alt_pattern(input int unsigned width);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < width && (i % 2) == 1) r = r | (BIT_ONE << i);
    end
    return r;
  endfunction

  // Only the two middle bits of a width-bit bank set.
  function automatic logic [MAX_W-1:0] centre_pattern(input int unsigned width);
    logic [MAX_W-1:0] r;
    r = (BIT_ONE << (width / 2)) | (BIT_ONE << (width / 2 - 1));
    return r;
  endfunction

endpackage

// File: rtl/led_pattern_seq_if.sv
// Control and observation bundle for the LED pattern sequencer.
interface led_pattern_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic             en;
  logic             dir;
  logic             step;
  logic [WIDTH-1:0] led;
  logic [1:0]       state;
  logic             tick;

  modport master (
    output en, dir, step,
    input  led, state, tick
  );

  modport slave (
    input  en, dir, step,
    output led, state, tick
  );
endinterface

// File: rtl/tick_gen.sv
// Free-running prescaler producing a one-cycle tick every 2^DIV_W clocks.
module tick_gen #(
  parameter int unsigned DIV_W = 25
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic [DIV_W-1:0] cnt_q;

  // Wrapping up-counter; never gated so the tick cadence is independent of use.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_q + DIV_W'(1);
  end

  assign tick = (cnt_q == '1);

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: all-on, flash, shift, expand/contract, looping to flash.
module led_pattern_seq
  import led_seq_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DIV_W       = 25,
  parameter int unsigned FLASH_STEPS = 1
) (
  input logic              clk,
  input logic              rst,
  led_pattern_seq_if.slave bus
);

  localparam int unsigned HALF = WIDTH / 2;
  localparam int unsigned CW   = $clog2(FLASH_STEPS + 1);

  localparam logic [WIDTH-1:0] ALT      = WIDTH'(alt_pattern(WIDTH));
  localparam logic [WIDTH-1:0] CENTRE   = WIDTH'(centre_pattern(WIDTH));
  localparam logic [CW-1:0]    CNT_LAST = CW'(FLASH_STEPS - 1);
  localparam logic [HALF-1:0]  H_ONE    = HALF'(1);
  localparam logic [HALF-1:0]  H_MSB    = {1'b1, {(HALF - 1){1'b0}}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [HALF-1:0]  upper, lower;
  logic             tick;
  logic             advance;

  tick_gen #(
    .DIV_W(DIV_W)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // step only counts while the sequencer is not free-running.
  assign advance = (bus.en && tick) || (!bus.en && bus.step);
  assign upper   = led_q[WIDTH-1:HALF];
  assign lower   = led_q[HALF-1:0];

  // Next pattern/state; everything holds unless an advance happens this cycle.
  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    cnt_d   = cnt_q;
    if (advance) begin
      unique case (state_q)
        ST_ALL_ON: begin
          state_d = ST_FLASH;
          led_d   = ALT;
          cnt_d   = '0;
        end
        ST_FLASH: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_SHIFT;
          end else begin
            led_d = ~led_q;
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_SHIFT: begin
          if (led_q == '0) begin
            state_d = ST_EXPAND;
            led_d   = CENTRE;
          end else if (!bus.dir) begin
            led_d = led_q >> 1;
          end else begin
            led_d = led_q << 1;
          end
        end
        ST_EXPAND: begin
          // Contracting always drains to zero, so this exit cannot be missed.
          if (led_q == '1 || led_q == '0) begin
            state_d = ST_FLASH;
            led_d   = ALT;
            cnt_d   = '0;
          end else if (!bus.dir) begin
            led_d = {(upper << 1) | H_ONE, (lower >> 1) | H_MSB};
          end else begin
            led_d = {upper >> 1, lower << 1};
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // State, pattern and flash counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ALL_ON;
      led_q   <= '1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.led   = led_q;
  assign bus.state = state_q;
  assign bus.tick  = tick;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Self-checking bench: an 8-bit/FLASH_STEPS=2 and a 16-bit/FLASH_STEPS=1 sequencer
// run side by side against an arithmetic reference model.
module tb_led_pattern_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  led_pattern_seq_if #(.WIDTH(8))  b0 ();
  led_pattern_seq_if #(.WIDTH(16)) b1 ();

  led_pattern_seq #(.WIDTH(8), .DIV_W(2), .FLASH_STEPS(2)) dut0 (
    .clk(clk), .rst(rst), .bus(b0)
  );
  led_pattern_seq #(.WIDTH(16), .DIV_W(2), .FLASH_STEPS(1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1)
  );

  // Reference model: 0 all-on, 1 flash, 2 shift, 3 expand
  int     m_state [2];
  longint m_led   [2];
  int     m_cnt   [2];
  int     m_div;
  int     mw      [2] = '{8, 16};
  int     mfs     [2] = '{2, 1};

  function automatic longint alt_val(input int w);
    longint r = 0;
    for (int i = 1; i < w; i += 2) r += (longint'(1) << i);
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_state[d] = 0;
      m_led[d]   = (longint'(1) << mw[d]) - 1;
      m_cnt[d]   = 0;
    end
    m_div = 0;
  endtask

  task automatic model_adv(input int d, input logic dir);
    longint full, hm, u, l;
    full = (longint'(1) << mw[d]) - 1;
    hm   = longint'(1) << (mw[d] / 2);
    case (m_state[d])
      0: begin m_state[d] = 1; m_led[d] = alt_val(mw[d]); m_cnt[d] = 0; end
      1: begin
        if (m_cnt[d] == mfs[d] - 1) m_state[d] = 2;
        else begin m_led[d] = full - m_led[d]; m_cnt[d]++; end
      end
      2: begin
        if (m_led[d] == 0) begin m_state[d] = 3; m_led[d] = hm + hm / 2; end
        else if (!dir) m_led[d] = m_led[d] / 2;
        else m_led[d] = (m_led[d] * 2) % (full + 1);
      end
      default: begin
        if (m_led[d] == full || m_led[d] == 0) begin
          m_state[d] = 1; m_led[d] = alt_val(mw[d]); m_cnt[d] = 0;
        end else begin
          u = m_led[d] / hm;
          l = m_led[d] % hm;
          if (!dir) begin u = (u * 2 + 1) % hm; l = l / 2 + hm / 2; end
          else begin u = u / 2; l = (l * 2) % hm; end
          m_led[d] = u * hm + l;
        end
      end
    endcase
  endtask

  // One clock: check tick, advance the model, clock the DUTs, check outputs.
  task automatic run_cycle();
    logic et, a0, a1;
    et = (m_div % 4 == 3);
    checks++;
    if (b0.tick !== et) begin
      errors++;
      $display("FAIL tick8: got %b expected %b at %0t", b0.tick, et, $time);
    end
    checks++;
    if (b1.tick !== et) begin
      errors++;
      $display("FAIL tick16: got %b expected %b at %0t", b1.tick, et, $time);
    end
    a0 = (b0.en && et) || (!b0.en && b0.step);
    a1 = (b1.en && et) || (!b1.en && b1.step);
    if (a0) model_adv(0, b0.dir);
    if (a1) model_adv(1, b1.dir);
    @(posedge clk);
    m_div++;
    #1;
    checks++;
    if (b0.led !== 8'(m_led[0]) || b0.state !== 2'(m_state[0])) begin
      errors++;
      $display("FAIL dut8: got led %h st %0d expected led %h st %0d at %0t",
               b0.led, b0.state, 8'(m_led[0]), m_state[0], $time);
    end
    checks++;
    if (b1.led !== 16'(m_led[1]) || b1.state !== 2'(m_state[1])) begin
      errors++;
      $display("FAIL dut16: got led %h st %0d expected led %h st %0d at %0t",
               b1.led, b1.state, 16'(m_led[1]), m_state[1], $time);
    end
  endtask

  task automatic set_inputs(input logic e0, d0, s0, e1, d1, s1);
    b0.en = e0; b0.dir = d0; b0.step = s0;
    b1.en = e1; b1.dir = d1; b1.step = s1;
  endtask

  // Ends between edges with reset released and the model reset.
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    set_inputs(0, 0, 0, 0, 0, 0);
    do_reset();
    checks++;
    if (b0.led !== 8'hFF) begin errors++; $display("FAIL rst_led8: got %h expected ff", b0.led); end
    checks++;
    if (b0.state !== 2'd0) begin errors++; $display("FAIL rst_st8: got %0d expected 0", b0.state); end
    checks++;
    if (b0.tick !== 1'b0) begin errors++; $display("FAIL rst_tick: got %b expected 0", b0.tick); end
    checks++;
    if (b1.led !== 16'hFFFF) begin
      errors++; $display("FAIL rst_led16: got %h expected ffff", b1.led);
    end
  endtask

  task automatic test_basic_sequence();
    logic [7:0] exp_led [11] = '{8'hAA, 8'h55, 8'h55, 8'h2A, 8'h15, 8'h0A, 8'h05, 8'h02,
                                 8'h01, 8'h00, 8'h18};
    logic [1:0] exp_st  [11] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                 2'd2, 2'd2, 2'd3};
    do_reset();
    set_inputs(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 11; k++) begin
      repeat (4) run_cycle();
      checks++;
      if (b0.led !== exp_led[k] || b0.state !== exp_st[k]) begin
        errors++;
        $display("FAIL seq[%0d]: got %h/%0d expected %h/%0d", k, b0.led, b0.state,
                 exp_led[k], exp_st[k]);
      end
    end
  endtask

  task automatic test_expand();
    logic [7:0] exp_led [4] = '{8'h3C, 8'h7E, 8'hFF, 8'hAA};
    logic [1:0] exp_st  [4] = '{2'd3, 2'd3, 2'd3, 2'd1};
    int n;
    b0.dir = 1'b0;
    for (int k = 0; k < 4; k++) begin
      repeat (4) run_cycle();
      checks++;
      if (b0.led !== exp_led[k] || b0.state !== exp_st[k]) begin
        errors++;
        $display("FAIL expand_out[%0d]: got %h/%0d expected %h/%0d", k, b0.led, b0.state,
                 exp_led[k], exp_st[k]);
      end
    end
    n = 0;
    while (!(b0.state == 2'd3 && b0.led == 8'h18) && n < 200) begin
      run_cycle();
      n++;
    end
    checks++;
    if (n >= 200) begin errors++; $display("FAIL reach_centre: got timeout expected 18/3"); end
    b0.dir = 1'b1;
    repeat (4) run_cycle();
    checks++;
    if (b0.led !== 8'h00 || b0.state !== 2'd3) begin
      errors++; $display("FAIL contract: got %h/%0d expected 00/3", b0.led, b0.state);
    end
    repeat (4) run_cycle();
    checks++;
    if (b0.led !== 8'hAA || b0.state !== 2'd1) begin
      errors++; $display("FAIL contract_exit: got %h/%0d expected aa/1", b0.led, b0.state);
    end
  endtask

  task automatic test_step();
    set_inputs(0, 0, 0, 0, 0, 0);
    for (int p = 0; p < 6; p++) begin
      b0.step = 1'b1; b1.step = 1'b1;
      b0.dir = 1'($urandom_range(0, 1));
      run_cycle();
      b0.step = 1'b0; b1.step = 1'b0;
      repeat (9) run_cycle();
    end
  endtask

  task automatic test_idle();
    longint snap_led;
    int     snap_st;
    set_inputs(0, 0, 0, 0, 0, 0);
    snap_led = m_led[0];
    snap_st  = m_state[0];
    repeat (100) run_cycle();
    checks++;
    if (b0.led !== 8'(snap_led) || b0.state !== 2'(snap_st)) begin
      errors++;
      $display("FAIL idle: got %h/%0d expected %h/%0d", b0.led, b0.state, 8'(snap_led), snap_st);
    end
  endtask

  task automatic test_step_ignored();
    do_reset();
    set_inputs(1, 0, 1, 0, 0, 0);
    repeat (8) run_cycle();
    b0.step = 1'b0;
    checks++;
    if (b0.led !== 8'h55 || b0.state !== 2'd1) begin
      errors++; $display("FAIL step_ignored: got %h/%0d expected 55/1", b0.led, b0.state);
    end
  endtask

  task automatic test_tick_period();
    int highs;
    highs = 0;
    do_reset();
    set_inputs(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      run_cycle();
      if (b0.tick === 1'b1) highs++;
    end
    checks++;
    if (highs !== 5) begin errors++; $display("FAIL tick_count: got %0d expected 5", highs); end
  endtask

  task automatic test_async_reset();
    int n, first;
    do_reset();
    set_inputs(1, 0, 0, 0, 0, 0);
    n = 0;
    while (b0.state != 2'd2 && n < 100) begin run_cycle(); n++; end
    checks++;
    if (n >= 100) begin errors++; $display("FAIL reach_shift: got timeout expected state 2"); end
    repeat (5) run_cycle();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (b0.led !== 8'hFF || b0.state !== 2'd0 || b0.tick !== 1'b0) begin
      errors++;
      $display("FAIL async_rst: got %h/%0d/%b expected ff/0/0", b0.led, b0.state, b0.tick);
    end
    checks++;
    if (b1.led !== 16'hFFFF) begin
      errors++; $display("FAIL async_rst16: got %h expected ffff", b1.led);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    first = -1;
    for (int i = 0; i < 8; i++) begin
      if (first < 0 && b0.tick === 1'b1) first = i;
      run_cycle();
    end
    checks++;
    if (first !== 3) begin errors++; $display("FAIL first_tick: got %0d expected 3", first); end
  endtask

  task automatic test_width16();
    logic [15:0] exp_led [3] = '{16'hAAAA, 16'hAAAA, 16'h5555};
    logic [1:0]  exp_st  [3] = '{2'd1, 2'd2, 2'd2};
    do_reset();
    set_inputs(0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      repeat (4) run_cycle();
      checks++;
      if (b1.led !== exp_led[k] || b1.state !== exp_st[k]) begin
        errors++;
        $display("FAIL w16[%0d]: got %h/%0d expected %h/%0d", k, b1.led, b1.state,
                 exp_led[k], exp_st[k]);
      end
    end
    do_reset();
    repeat (8) run_cycle();
    b1.dir = 1'b1;
    repeat (4) run_cycle();
    checks++;
    if (b1.led !== 16'h5554 || b1.state !== 2'd2) begin
      errors++; $display("FAIL w16_left: got %h/%0d expected 5554/2", b1.led, b1.state);
    end
    repeat (4) run_cycle();
    checks++;
    if (b1.led !== 16'hAAA8) begin
      errors++; $display("FAIL w16_left2: got %h expected aaa8", b1.led);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      b0.en   = ($urandom_range(0, 2) == 0);
      b0.dir  = 1'($urandom_range(0, 1));
      b0.step = ($urandom_range(0, 2) == 0);
      b1.en   = ($urandom_range(0, 2) == 0);
      b1.dir  = 1'($urandom_range(0, 1));
      b1.step = ($urandom_range(0, 2) == 0);
      run_cycle();
    end
  endtask

  initial begin
    set_inputs(0, 0, 0, 0, 0, 0);
    model_reset();
    test_reset();
    test_basic_sequence();
    test_expand();
    test_step();
    test_idle();
    test_step_ignored();
    test_tick_period();
    test_async_reset();
    test_width16();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
